mux_8_1_scan: RTL and testbench

MUX_8_1_SCAN -- requirements
Module: mux_8_1_scan

---
 rtl/mux_8_1_scan.sv | 143 ++++++++++++++
 tb/tb_mux_8_1_scan.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_8_1_scan.sv
// mux_8_1_scan: captures an 8-bit parallel word on a start request and
// replays it one channel per cycle on a serial output, with the channel
// index alongside. The walk direction is set by LSB_FIRST. i_hold stalls
// the walk. A one-cycle done pulse closes each scan.
// Optional feature: define MUX_8_1_SCAN_PARITY_EN to register the XOR of the
// captured word on o_parity. Without it, o_parity is tied to 0.
module mux_8_1_scan #(
    parameter int LSB_FIRST = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_hold,
    input  logic [7:0] i_code,
    output logic       o_a,
    output logic [2:0] o_sel_code,
    output logic       o_valid,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_parity
);

    // The first and last channels visited depend on the scan direction.
    localparam logic [2:0] FIRST_CH = (LSB_FIRST != 0) ? 3'd0 : 3'd7;
    localparam logic [2:0] LAST_CH  = (LSB_FIRST != 0) ? 3'd7 : 3'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_snap;
    logic [2:0] r_cnt;
    logic       r_a;
    logic       w_capture;
    logic       w_advance;
    logic       w_step;
    logic [2:0] w_next_cnt;

    // A capture happens only from IDLE; requests elsewhere are ignored.
    assign w_capture = (r_state == ST_IDLE) && i_start;

    // The scan moves forward on every unstalled SCAN cycle.
    assign w_advance = (r_state == ST_SCAN) && !i_hold;

    // The counter steps only while not on the last channel, so it never wraps.
    assign w_step = w_advance && (r_cnt != LAST_CH);

    // The direction of the step follows the configured scan order.
    assign w_next_cnt = (LSB_FIRST != 0) ? (r_cnt + 3'd1) : (r_cnt - 3'd1);

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: DONE always lasts one cycle regardless of i_hold.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_next_state = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (w_advance && (r_cnt == LAST_CH)) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Status outputs decoded from the registered state. A stalled beat is not valid.
    always_comb begin
        o_valid = 1'b0;
        o_busy  = 1'b0;
        o_done  = 1'b0;
        case (r_state)
            ST_SCAN: begin
                o_busy  = 1'b1;
                o_valid = !i_hold;
            end
            ST_DONE: begin
                o_busy = 1'b1;
                o_done = 1'b1;
            end
            default: begin
                o_busy = 1'b0;
            end
        endcase
    end

    // Snapshot, channel counter and serial bit. Their last values are held outside a scan.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_snap <= 8'd0;
            r_cnt  <= 3'd0;
            r_a    <= 1'b0;
        end else if (w_capture) begin
            r_snap <= i_code;
            r_cnt  <= FIRST_CH;
            r_a    <= i_code[FIRST_CH];
        end else if (w_step) begin
            r_cnt  <= w_next_cnt;
            r_a    <= r_snap[w_next_cnt];
        end
    end

    assign o_a        = r_a;
    assign o_sel_code = r_cnt;

`ifdef MUX_8_1_SCAN_PARITY_EN
    logic r_parity;

    // Parity of the captured word, held until the next capture.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_parity <= 1'b0;
        end else if (w_capture) begin
            r_parity <= ^i_code;
        end
    end

    assign o_parity = r_parity;
`else
    assign o_parity = 1'b0;
`endif

endmodule

// File: tb/tb_mux_8_1_scan.sv
// Bench for mux_8_1_scan: runs one instance of each scan direction side by side.
// A per-beat reference model checks every output on every cycle. Each scan
// is then also checked for the rebuilt word, the beat count, the cycle count
// and the number of done pulses.
module tb_mux_8_1_scan;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       hold;
    logic [7:0] code;

    logic       w_a     [2];
    logic [2:0] w_sel   [2];
    logic       w_valid [2];
    logic       w_busy  [2];
    logic       w_done  [2];
    logic       w_par   [2];

    mux_8_1_scan #(.LSB_FIRST(1)) u_lsb (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_hold(hold), .i_code(code),
        .o_a(w_a[0]), .o_sel_code(w_sel[0]), .o_valid(w_valid[0]), .o_busy(w_busy[0]),
        .o_done(w_done[0]), .o_parity(w_par[0])
    );

    mux_8_1_scan #(.LSB_FIRST(0)) u_msb (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_hold(hold), .i_code(code),
        .o_a(w_a[1]), .o_sel_code(w_sel[1]), .o_valid(w_valid[1]), .o_busy(w_busy[1]),
        .o_done(w_done[1]), .o_parity(w_par[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model. Instance 0 walks channels 0..7; instance 1 walks 7..0.
    // State: 0 idle, 1 scanning, 2 done cycle.
    int         m_st   [2];
    int         m_beat [2];
    logic [7:0] m_snap [2];
    logic [2:0] m_sel  [2];
    logic       m_a    [2];
    logic       m_par  [2];

    function automatic int chan(input int k, input int n);
        return (k == 0) ? n : 7 - n;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 0; m_beat[k] = 0; m_snap[k] = 8'd0;
            m_sel[k] = 3'd0; m_a[k] = 1'b0; m_par[k] = 1'b0;
        end
    endtask

    task automatic model_step(input int k);
        int c;
        case (m_st[k])
            0: if (start) begin
                m_snap[k] = code;
                m_beat[k] = 0;
                c = chan(k, 0);
                m_sel[k] = 3'(c);
                m_a[k] = code[c];
`ifdef MUX_8_1_SCAN_PARITY_EN
                m_par[k] = ^code;
`endif
                m_st[k] = 1;
            end
            1: if (!hold) begin
                if (m_beat[k] == 7) begin
                    m_st[k] = 2;
                end else begin
                    m_beat[k]++;
                    c = chan(k, m_beat[k]);
                    m_sel[k] = 3'(c);
                    m_a[k] = m_snap[k][c];
                end
            end
            default: m_st[k] = 0;
        endcase
    endtask

    // Per-scan observations taken from the DUT outputs.
    logic [7:0] o_word  [2];
    int         o_nval  [2];
    int         o_ncyc  [2];
    int         o_ndone [2];
    int         o_first [2];

    task automatic clear_obs();
        for (int k = 0; k < 2; k++) begin
            o_word[k] = 8'd0; o_nval[k] = 0; o_ncyc[k] = 0;
            o_ndone[k] = 0; o_first[k] = -1;
        end
    endtask

    task automatic compare_and_observe(input int k);
        string s;
        s = (k == 0) ? "lsb" : "msb";
        chk({s, "_valid"}, int'(w_valid[k]), int'(m_st[k] == 1 && !hold));
        chk({s, "_busy"},  int'(w_busy[k]),  int'(m_st[k] != 0));
        chk({s, "_done"},  int'(w_done[k]),  int'(m_st[k] == 2));
        chk({s, "_sel"},   int'(w_sel[k]),   int'(m_sel[k]));
        chk({s, "_a"},     int'(w_a[k]),     int'(m_a[k]));
        chk({s, "_parity"}, int'(w_par[k]),  int'(m_par[k]));
        if (w_valid[k] === 1'b1) begin
            if (o_nval[k] == 0) o_first[k] = int'(w_sel[k]);
            o_word[k][w_sel[k]] = w_a[k];
            o_nval[k]++;
        end
        if (w_busy[k] === 1'b1 && w_done[k] !== 1'b1) o_ncyc[k]++;
        if (w_done[k] === 1'b1) o_ndone[k]++;
    endtask

    // One clock: check at the falling edge, advance the model at the rising edge.
    task automatic tick();
        @(negedge clk);
        for (int k = 0; k < 2; k++) compare_and_observe(k);
        @(posedge clk);
        if (rst_n) begin
            for (int k = 0; k < 2; k++) model_step(k);
        end
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk({tag, "_a"},     int'(w_a[k]),     0);
            chk({tag, "_sel"},   int'(w_sel[k]),   0);
            chk({tag, "_valid"}, int'(w_valid[k]), 0);
            chk({tag, "_busy"},  int'(w_busy[k]),  0);
            chk({tag, "_done"},  int'(w_done[k]),  0);
            chk({tag, "_par"},   int'(w_par[k]),   0);
        end
    endtask

    // Asserts reset between edges and checks the outputs clear before any edge.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check_all_zero(tag);
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // hmode: 0 no stall, 1 stall hlen cycles when the LSB instance shows channel hsel,
    // 2 random stall. scramble: new i_code and random i_start every cycle of the scan.
    task automatic run_scan(input string tag, input logic [7:0] word, input int hmode,
                            input int hsel, input int hlen, input bit scramble);
        int   left;
        int   nhold;
        bit   fin;
        left  = hlen;
        nhold = 0;
        fin   = 1'b0;
        clear_obs();
        code  = word;
        start = 1'b1;
        hold  = (hmode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
        start = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (m_st[0] == 0 && m_st[1] == 0) begin
                fin = 1'b1;
                break;
            end
            hold = 1'b0;
            if (hmode == 1 && m_st[0] == 1 && int'(m_sel[0]) == hsel && left > 0) begin
                hold = 1'b1;
                left--;
            end else if (hmode == 2) begin
                hold = ($urandom_range(0, 3) == 0);
            end
            if (hold && m_st[0] == 1) nhold++;
            if (scramble) begin
                code  = 8'($urandom);
                start = 1'($urandom_range(0, 1));
            end
            tick();
        end
        start = 1'b0;
        hold  = 1'b0;
        chk({tag, "_finished"}, int'(fin), 1);
        for (int k = 0; k < 2; k++) begin
            chk({tag, "_word"},  int'(o_word[k]), int'(word));
            chk({tag, "_beats"}, o_nval[k], 8);
            chk({tag, "_cycles"}, o_ncyc[k], 8 + nhold);
            chk({tag, "_ndone"}, o_ndone[k], 1);
            chk({tag, "_first"}, o_first[k], (k == 0) ? 0 : 7);
        end
    endtask

    initial begin
        int guard;
        rst_n = 1'b0;
        start = 1'b0;
        hold  = 1'b0;
        code  = 8'd0;
        model_reset();
        #2;
        check_all_zero("por");
        tick();
        tick();
        rst_n = 1'b1;

        // Basic scan, both directions.
        run_scan("basic", 8'b1010_0110, 0, 0, 0, 1'b0);
        tick();
        // Reverse-order pattern.
        run_scan("rev81", 8'h81, 0, 0, 0, 1'b0);
        // Three-cycle stall on channel 3.
        run_scan("stall", 8'h5C, 1, 3, 3, 1'b0);
        // Captured word must survive input churn and start pulses during the scan.
        run_scan("snap", 8'h3B, 0, 0, 0, 1'b1);
        tick();

        // Parity of 8'h07 is visible from the first scan cycle.
        clear_obs();
        code  = 8'h07;
        start = 1'b1;
        tick();
        start = 1'b0;
`ifdef MUX_8_1_SCAN_PARITY_EN
        chk("parity07", int'(w_par[0]), 1);
`else
        chk("parity07", int'(w_par[0]), 0);
`endif
        for (int c = 0; c < 12; c++) tick();

        // Reset asserted mid-scan at channel 4, then a fresh scan.
        clear_obs();
        code  = 8'($urandom);
        start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (!(m_st[0] == 1 && m_sel[0] == 3'd4) && guard < 12) begin
            tick();
            guard++;
        end
        chk("midrst_reached", int'(m_sel[0]), 4);
        do_reset("midrst");
        chk("midrst_ndone0", o_ndone[0], 0);
        chk("midrst_ndone1", o_ndone[1], 0);
        run_scan("after_rst", 8'hC4, 0, 0, 0, 1'b0);

        // Randomized scans with random stalls and occasional input churn.
        for (int i = 0; i < 25; i++) begin
            run_scan("rand", 8'($urandom), 2, 0, 0, 1'($urandom_range(0, 1)));
            for (int g = $urandom_range(0, 2); g > 0; g--) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
